// File: rtl/i2c_target_regs_if.sv
// Local register-file side of the I2C target: asynchronous read port plus write notification.
interface i2c_target_regs_if;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport slave  (input rd_addr, output rd_data, wr_strobe, wr_addr, wr_data, busy);
  modport master (output rd_addr, input rd_data, wr_strobe, wr_addr, wr_data, busy);
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 256-byte register file with an auto-incrementing pointer.
// SCL/SDA are oversampled on sys_clk, synchronised and glitch filtered; SCL is never stretched.
module i2c_target_regs #(
  parameter logic [6:0]  I2C_ADDRESS = 7'b1110000,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             SCL,
  inout  wire              SDA,
  i2c_target_regs_if.slave regs
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned DEPTH = 256;

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  logic             scl_meta, scl_sync, sda_meta, sda_sync;
  logic [CNT_W-1:0] scl_cnt, sda_cnt;
  logic             scl_f, sda_f, scl_q, sda_q;
  logic             scl_rise, scl_fall, start_det, stop_det;

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic [7:0]       ptr;
  logic [7:0]       ptr_next;
  logic             ack_phase;
  logic             rd_mode;
  logic             master_ack;
  logic             sda_oe;
  logic             busy;
  logic             wr_strobe;
  logic [7:0]       wr_addr;
  logic [7:0]       wr_data;
  logic [7:0]       rx_byte;
  logic [7:0]       ptr_data;
  logic [7:0]       next_data;

  logic [7:0]       regfile [DEPTH];
  logic [DEPTH-1:0] valid;

  // Two-flop synchronisers, idle-high
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      scl_meta <= SCL;
      scl_sync <= scl_meta;
      sda_meta <= SDA;
      sda_sync <= sda_meta;
    end
  end

  // A new level is accepted only after FILTER_LEN consecutive differing samples
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
      if (scl_sync == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CNT_W'(FILTER_LEN - 1)) begin
        scl_f   <= scl_sync;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + CNT_W'(1);
      end
      if (sda_sync == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CNT_W'(FILTER_LEN - 1)) begin
        sda_f   <= sda_sync;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + CNT_W'(1);
      end
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

  assign rx_byte   = {shift_reg[6:0], sda_f};
  assign ptr_next  = ptr + 8'd1;
  assign ptr_data  = valid[ptr] ? regfile[ptr] : 8'h00;
  assign next_data = valid[ptr_next] ? regfile[ptr_next] : 8'h00;

  // Protocol FSM; every bus-facing output is a register updated here
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      ptr        <= '0;
      ack_phase  <= 1'b0;
      rd_mode    <= 1'b0;
      master_ack <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state     <= DEV_ADDR;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          DEV_ADDR, REG_ADDR, WR_DATA: begin
            if (scl_rise) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_phase <= 1'b0;
                if (state == DEV_ADDR) begin
                  if (rx_byte[7:1] == I2C_ADDRESS) begin
                    state   <= DEV_ACK;
                    rd_mode <= rx_byte[0];
                    busy    <= 1'b1;
                  end else begin
                    state <= WAIT_STOP;
                  end
                end else if (state == REG_ADDR) begin
                  ptr   <= rx_byte;
                  state <= REG_ACK;
                end else begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                  wr_data   <= rx_byte;
                  state     <= WR_ACK;
                end
              end
            end
          end
          // First falling edge starts the ACK drive, second one ends the ACK clock
          DEV_ACK, REG_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                ack_phase <= 1'b1;
                sda_oe    <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                bit_cnt   <= '0;
                if (state == DEV_ACK) begin
                  if (rd_mode) begin
                    state     <= RD_DATA;
                    shift_reg <= ptr_data;
                    sda_oe    <= ~ptr_data[7];
                  end else begin
                    state <= REG_ADDR;
                  end
                end else if (state == REG_ACK) begin
                  state <= WR_DATA;
                end else begin
                  ptr   <= ptr_next;
                  state <= WR_DATA;
                end
              end
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              sda_oe <= ~shift_reg[7];
            end else if (scl_rise) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state     <= RD_ACK;
                ack_phase <= 1'b0;
              end
            end
          end
          RD_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                ack_phase <= 1'b1;
                sda_oe    <= 1'b0;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                if (master_ack) begin
                  ptr       <= ptr_next;
                  state     <= RD_DATA;
                  shift_reg <= next_data;
                  sda_oe    <= ~next_data[7];
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end else if (scl_rise && ack_phase) begin
              master_ack <= ~sda_f;
            end
          end
          IDLE, WAIT_STOP: begin
            sda_oe <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  // Valid bits give the all-zero reset image without clearing the array itself
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      valid <= '0;
    end else if (wr_strobe) begin
      valid[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_strobe) begin
      regfile[wr_addr] <= wr_data;
    end
  end

  assign SDA            = sda_oe ? 1'b0 : 1'bz;
  assign regs.rd_data   = valid[regs.rd_addr] ? regfile[regs.rd_addr] : 8'h00;
  assign regs.wr_strobe = wr_strobe;
  assign regs.wr_addr   = wr_addr;
  assign regs.wr_data   = wr_data;
  assign regs.busy      = busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller, register-file model and per-feature tests.
module tb_i2c_target_regs;
  localparam int Q = 8;

  logic sys_clk    = 1'b0;
  logic sys_rst    = 1'b0;
  logic scl_drv    = 1'b1;
  logic tb_sda_low = 1'b0;
  wire  sda;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mem [256];
  logic [7:0]  mptr;
  logic [7:0]  xbuf [16];
  logic [15:0] strobe_log [$];
  int          dut_low_cnt = 0;

  i2c_target_regs_if regs();

  i2c_target_regs #(.I2C_ADDRESS(7'b1110000), .FILTER_LEN(3)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .SCL     (scl_drv),
    .SDA     (sda),
    .regs    (regs)
  );

  pullup pu_sda (sda);
  assign sda = tb_sda_low ? 1'b0 : 1'bz;

  always #5 sys_clk = ~sys_clk;

  // Observe strobes and target-driven lows well clear of both clock edges
  always @(posedge sys_clk) begin
    #2;
    if (regs.wr_strobe === 1'b1) strobe_log.push_back({regs.wr_addr, regs.wr_data});
    if (sda === 1'b0 && !tb_sda_low) dut_low_cnt++;
  end

  task automatic wait_q();
    repeat (Q) @(negedge sys_clk);
  endtask

  task automatic bus_start();
    if (scl_drv == 1'b0) begin
      tb_sda_low = 1'b0; wait_q();
      scl_drv = 1'b1;    wait_q();
    end
    tb_sda_low = 1'b1; wait_q();
    scl_drv = 1'b0;    wait_q();
  endtask

  task automatic bus_stop();
    tb_sda_low = 1'b1; wait_q();
    scl_drv = 1'b1;    wait_q();
    tb_sda_low = 1'b0; wait_q();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    tb_sda_low = ~b; wait_q();
    scl_drv = 1'b1;  wait_q();
    s = sda;         wait_q();
    scl_drv = 1'b0;  wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(~ack, s);
  endtask

  task automatic do_write(input logic [7:0] p, input int n, output int acks);
    logic a;
    acks = 0;
    bus_start();
    send_byte(8'hE0, a); acks += int'(a);
    send_byte(p, a);     acks += int'(a);
    for (int i = 0; i < n; i++) begin
      send_byte(xbuf[i], a); acks += int'(a);
    end
    bus_stop();
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n, output int acks);
    logic a;
    logic [7:0] b;
    acks = 0;
    bus_start();
    if (set_ptr) begin
      send_byte(8'hE0, a); acks += int'(a);
      send_byte(p, a);     acks += int'(a);
      bus_start();
    end
    send_byte(8'hE1, a); acks += int'(a);
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, b);
      xbuf[i] = b;
    end
    bus_stop();
  endtask

  task automatic test_reset();
    logic [7:0] a;
    regs.rd_addr = 8'h00;
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mptr = 8'h00;
    n_cmp++; if (regs.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", regs.busy); end
    n_cmp++; if (regs.wr_strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b want 0", regs.wr_strobe); end
    n_cmp++; if (regs.wr_addr !== 8'h00 || regs.wr_data !== 8'h00) begin
      n_err++; $display("FAIL reset_wr: got %h/%h want 00/00", regs.wr_addr, regs.wr_data); end
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b want 1", sda); end
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      regs.rd_addr = a;
      @(negedge sys_clk);
      n_cmp++; if (regs.rd_data !== 8'h00) begin
        n_err++; $display("FAIL reset_regfile[%h]: got %h want 00", a, regs.rd_data); end
    end
  endtask

  task automatic test_write();
    logic a;
    int s0;
    s0 = strobe_log.size();
    bus_start();
    send_byte(8'hE0, a);
    n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL wr_dev_ack: got %b want 1", a); end
    n_cmp++; if (regs.busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", regs.busy); end
    send_byte(8'h10, a);
    n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL wr_reg_ack: got %b want 1", a); end
    send_byte(8'hAA, a);
    n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL wr_data0_ack: got %b want 1", a); end
    send_byte(8'h55, a);
    n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL wr_data1_ack: got %b want 1", a); end
    bus_stop();
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'h55; mptr = 8'h12;
    n_cmp++; if (regs.busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_stop: got %b want 0", regs.busy); end
    n_cmp++; if (strobe_log.size() - s0 != 2) begin
      n_err++; $display("FAIL wr_strobe_count: got %0d want 2", strobe_log.size() - s0); end
    else begin
      n_cmp++; if (strobe_log[s0] !== 16'h10AA || strobe_log[s0 + 1] !== 16'h1155) begin
        n_err++; $display("FAIL wr_strobe_vals: got %h,%h want 10aa,1155", strobe_log[s0], strobe_log[s0 + 1]); end
    end
    regs.rd_addr = 8'h11;
    @(negedge sys_clk);
    n_cmp++; if (regs.rd_data !== 8'h55) begin n_err++; $display("FAIL wr_rd_data11: got %h want 55", regs.rd_data); end
  endtask

  task automatic test_read();
    logic a;
    logic [7:0] b0, b1;
    bus_start();
    send_byte(8'hE0, a);
    send_byte(8'h10, a);
    bus_start();
    send_byte(8'hE1, a);
    n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL rd_dev_ack: got %b want 1", a); end
    recv_byte(1'b1, b0);
    recv_byte(1'b0, b1);
    n_cmp++; if (regs.busy !== 1'b1) begin n_err++; $display("FAIL rd_busy: got %b want 1", regs.busy); end
    bus_stop();
    mptr = 8'h11;
    n_cmp++; if (b0 !== mem[8'h10]) begin n_err++; $display("FAIL rd_byte0: got %h want %h", b0, mem[8'h10]); end
    n_cmp++; if (b1 !== mem[8'h11]) begin n_err++; $display("FAIL rd_byte1: got %h want %h", b1, mem[8'h11]); end
    n_cmp++; if (regs.busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_stop: got %b want 0", regs.busy); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int s0, l0;
    s0 = strobe_log.size();
    l0 = dut_low_cnt;
    bus_start();
    send_byte(8'hE2, a0);
    n_cmp++; if (regs.busy !== 1'b0) begin n_err++; $display("FAIL mm_busy: got %b want 0", regs.busy); end
    send_byte(8'h00, a1);
    bus_stop();
    n_cmp++; if (a0 !== 1'b0 || a1 !== 1'b0) begin n_err++; $display("FAIL mm_ack: got %b%b want 00", a0, a1); end
    n_cmp++; if (dut_low_cnt != l0) begin n_err++; $display("FAIL mm_sda_low: got %0d want 0", dut_low_cnt - l0); end
    n_cmp++; if (strobe_log.size() != s0) begin
      n_err++; $display("FAIL mm_strobe: got %0d want 0", strobe_log.size() - s0); end
  endtask

  task automatic test_wrap();
    int acks;
    xbuf[0] = 8'h11; xbuf[1] = 8'h22;
    do_write(8'hFF, 2, acks);
    mem[8'hFF] = 8'h11; mem[8'h00] = 8'h22; mptr = 8'h01;
    n_cmp++; if (acks != 4) begin n_err++; $display("FAIL wrap_acks: got %0d want 4", acks); end
    regs.rd_addr = 8'hFF;
    @(negedge sys_clk);
    n_cmp++; if (regs.rd_data !== 8'h11) begin n_err++; $display("FAIL wrap_ff: got %h want 11", regs.rd_data); end
    regs.rd_addr = 8'h00;
    @(negedge sys_clk);
    n_cmp++; if (regs.rd_data !== 8'h22) begin n_err++; $display("FAIL wrap_00: got %h want 22", regs.rd_data); end
  endtask

  task automatic test_glitch();
    logic a;
    int l0;
    l0 = dut_low_cnt;
    tb_sda_low = 1'b1;
    repeat (2) @(negedge sys_clk);
    tb_sda_low = 1'b0;
    wait_q();
    // Without a real START, a matching address must be ignored
    scl_drv = 1'b0; wait_q();
    send_byte(8'hE0, a);
    n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL glitch_ack: got %b want 0", a); end
    n_cmp++; if (regs.busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b want 0", regs.busy); end
    n_cmp++; if (dut_low_cnt != l0) begin n_err++; $display("FAIL glitch_sda_low: got %0d want 0", dut_low_cnt - l0); end
    bus_stop();
  endtask

  task automatic test_random();
    logic [7:0] p;
    logic       set_ptr;
    int         n, acks, s0;
    for (int t = 0; t < 6; t++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) xbuf[i] = 8'($urandom);
      s0 = strobe_log.size();
      do_write(p, n, acks);
      n_cmp++; if (acks != n + 2) begin n_err++; $display("FAIL rnd_wr_acks: got %0d want %0d", acks, n + 2); end
      n_cmp++; if (strobe_log.size() - s0 != n) begin
        n_err++; $display("FAIL rnd_strobe_count: got %0d want %0d", strobe_log.size() - s0, n); end
      mptr = p;
      for (int i = 0; i < n; i++) begin
        mem[mptr] = xbuf[i];
        if (s0 + i < strobe_log.size()) begin
          n_cmp++; if (strobe_log[s0 + i] !== {mptr, xbuf[i]}) begin
            n_err++; $display("FAIL rnd_strobe: got %h want %h", strobe_log[s0 + i], {mptr, xbuf[i]}); end
        end
        regs.rd_addr = mptr;
        @(negedge sys_clk);
        n_cmp++; if (regs.rd_data !== mem[mptr]) begin
          n_err++; $display("FAIL rnd_local[%h]: got %h want %h", mptr, regs.rd_data, mem[mptr]); end
        mptr = mptr + 8'd1;
      end
      set_ptr = 1'($urandom_range(0, 1));
      p = 8'($urandom);
      n = $urandom_range(1, 3);
      do_read(set_ptr, p, n, acks);
      n_cmp++; if (acks != (set_ptr ? 3 : 1)) begin
        n_err++; $display("FAIL rnd_rd_acks: got %0d want %0d", acks, set_ptr ? 3 : 1); end
      if (set_ptr) mptr = p;
      for (int i = 0; i < n; i++) begin
        n_cmp++; if (xbuf[i] !== mem[mptr]) begin
          n_err++; $display("FAIL rnd_rd[%h]: got %h want %h", mptr, xbuf[i], mem[mptr]); end
        if (i < n - 1) mptr = mptr + 8'd1;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    int acks;
    logic [7:0] a8;
    xbuf[0] = 8'h3C;
    do_write(8'h40, 1, acks);
    mem[8'h40] = 8'h3C; mptr = 8'h41;
    bus_start();
    send_byte(8'hE0, a);
    send_byte(8'h40, a);
    bus_start();
    send_byte(8'hE1, a);
    // Target now drives the MSB (0) of 0x3C
    n_cmp++; if (sda !== 1'b0) begin n_err++; $display("FAIL rstmid_driving: got %b want 0", sda); end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL rstmid_sda: got %b want 1", sda); end
    n_cmp++; if (regs.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", regs.busy); end
    regs.rd_addr = 8'h40;
    @(negedge sys_clk);
    n_cmp++; if (regs.rd_data !== 8'h00) begin n_err++; $display("FAIL rstmid_regfile40: got %h want 00", regs.rd_data); end
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mptr = 8'h00;
    a8 = 8'($urandom);
    regs.rd_addr = a8;
    @(negedge sys_clk);
    n_cmp++; if (regs.rd_data !== 8'h00) begin n_err++; $display("FAIL rstmid_regfile[%h]: got %h want 00", a8, regs.rd_data); end
    scl_drv = 1'b1;
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b1;
    wait_q();
    // Read with no pointer set after reset uses pointer 0
    do_read(1'b0, 8'h00, 1, acks);
    n_cmp++; if (acks != 1) begin n_err++; $display("FAIL rstmid_rd_ack: got %0d want 1", acks); end
    n_cmp++; if (xbuf[0] !== mem[mptr]) begin n_err++; $display("FAIL rstmid_rd0: got %h want %h", xbuf[0], mem[mptr]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_glitch();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
